// File: rtl/main_mem_rr.sv
// Line-granular main memory shared by NUM_CH requesters through a round-robin arbiter.
// One whole line moves per access with fixed read/write latency and per-word write mask.
module main_mem_rr #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 8,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned RD_CYCLE      = 10,
  parameter int unsigned WR_CYCLE      = 10
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CH-1:0]                             req,
  input  logic [NUM_CH-1:0]                             we,
  input  logic [NUM_CH*ADDR_LEN-1:0]                    addr,
  input  logic [NUM_CH*(2**LINE_ADDR_LEN)*DATA_W-1:0]   wr_line,
  input  logic [NUM_CH*(2**LINE_ADDR_LEN)-1:0]          wr_mask,
  output logic [NUM_CH-1:0]                             gnt,
  output logic [(2**LINE_ADDR_LEN)*DATA_W-1:0]          rd_line,
  output logic                                          busy
);

  localparam int unsigned LINE_SIZE = 2 ** LINE_ADDR_LEN;
  localparam int unsigned LINE_W    = LINE_SIZE * DATA_W;
  localparam int unsigned MAX_LAT   = (RD_CYCLE > WR_CYCLE) ? RD_CYCLE : WR_CYCLE;
  localparam int unsigned CNT_W     = $clog2(MAX_LAT) + 1;
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MEM_AW    = ADDR_LEN + LINE_ADDR_LEN;
  localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;
  localparam int unsigned WR_OFF    = WR_CYCLE - LINE_SIZE;

  if (RD_CYCLE < LINE_SIZE + 1) begin : g_rd_lat_chk
    $error("main_mem_rr: RD_CYCLE must be at least LINE_SIZE+1");
  end
  if (WR_CYCLE < LINE_SIZE) begin : g_wr_lat_chk
    $error("main_mem_rr: WR_CYCLE must be at least LINE_SIZE");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_n;
  logic [CNT_W-1:0]        cnt_q, lat_end_c;
  logic [CH_W-1:0]         last_q, win_q, win_c;
  logic                    any_c, accept_c, finish_c;
  logic                    we_q;
  logic [ADDR_LEN-1:0]     addr_q;
  logic [LINE_W-1:0]       line_q;
  logic [LINE_SIZE-1:0]    mask_q;
  logic [DATA_W-1:0]       mem [MEM_DEPTH];
  logic [DATA_W-1:0]       rdata_q;
  logic [LINE_W-1:0]       latch_q, latch_c;
  logic                    wr_en_c, rd_en_c, cap_c;
  logic [LINE_ADDR_LEN-1:0] widx_c, ridx_c, cidx_c;

  // Round-robin pick: first requester after the last winner.
  always_comb begin
    win_c = '0;
    any_c = 1'b0;
    for (int i = 1; i <= int'(NUM_CH); i++) begin
      if (!any_c && req[(int'(last_q) + i) % int'(NUM_CH)]) begin
        any_c = 1'b1;
        win_c = CH_W'((int'(last_q) + i) % int'(NUM_CH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    accept_c  = 1'b0;
    finish_c  = 1'b0;
    lat_end_c = we_q ? CNT_W'(WR_CYCLE - 1) : CNT_W'(RD_CYCLE - 1);
    unique case (state_q)
      IDLE: if (any_c) begin
        accept_c = 1'b1;
        state_n  = BUSY;
      end
      BUSY: if (cnt_q == lat_end_c) begin
        finish_c = 1'b1;
        state_n  = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      busy    <= 1'b0;
      rd_line <= '0;
      cnt_q   <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
    end else begin
      busy <= (state_n != IDLE);
      gnt  <= finish_c ? (NUM_CH'(1) << win_q) : '0;
      if (accept_c)               cnt_q <= '0;
      else if (state_q == BUSY)   cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == DONE)        last_q <= win_q;
      if (finish_c && !we_q)      rd_line <= latch_c;
    end
  end

  // Request is captured at acceptance; requester inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      win_q  <= win_c;
      we_q   <= we[win_c];
      addr_q <= addr[win_c*ADDR_LEN +: ADDR_LEN];
      line_q <= wr_line[win_c*LINE_W +: LINE_W];
      mask_q <= wr_mask[win_c*LINE_SIZE +: LINE_SIZE];
    end
  end

  always_comb begin
    widx_c  = LINE_ADDR_LEN'(cnt_q - CNT_W'(WR_OFF));
    ridx_c  = LINE_ADDR_LEN'(cnt_q);
    cidx_c  = LINE_ADDR_LEN'(cnt_q - CNT_W'(1));
    wr_en_c = (state_q == BUSY) && we_q && (cnt_q >= CNT_W'(WR_OFF)) && mask_q[widx_c];
    rd_en_c = (state_q == BUSY) && !we_q && (cnt_q < CNT_W'(LINE_SIZE));
    cap_c   = (state_q == BUSY) && !we_q && (cnt_q >= CNT_W'(1)) && (cnt_q <= CNT_W'(LINE_SIZE));
    latch_c = latch_q;
    if (cap_c) latch_c[cidx_c*DATA_W +: DATA_W] = rdata_q;
  end

  // Word-serial store: one write or one synchronous read per cycle.
  always_ff @(posedge clk) begin
    if (wr_en_c && !rst) mem[{addr_q, widx_c}] <= line_q[widx_c*DATA_W +: DATA_W];
    if (rd_en_c)         rdata_q <= mem[{addr_q, ridx_c}];
    latch_q <= latch_c;
  end

endmodule

// File: tb/tb_main_mem_rr.sv
// Scoreboard bench for main_mem_rr: drivers queue expected completions, a gnt monitor checks them.
module tb_main_mem_rr;
  localparam int NCH = 2;
  localparam int LAL = 3;
  localparam int LS  = 8;
  localparam int AL  = 8;
  localparam int DW  = 32;
  localparam int RDC = 10;
  localparam int WRC = 10;
  localparam int LW  = LS * DW;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]     req, we, gnt;
  logic [NCH*AL-1:0]  addr;
  logic [NCH*LW-1:0]  wr_line;
  logic [NCH*LS-1:0]  wr_mask;
  logic [LW-1:0]      rd_line;
  logic               busy;

  logic               m_req, m_we, m_busy;
  logic [0:0]         m_gnt;
  logic [AL-1:0]      m_addr;
  logic [LW-1:0]      m_wr_line, m_rd_line;
  logic [LS-1:0]      m_wr_mask;

  main_mem_rr #(.NUM_CH(NCH), .LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .DATA_W(DW),
                .RD_CYCLE(RDC), .WR_CYCLE(WRC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wr_line(wr_line),
    .wr_mask(wr_mask), .gnt(gnt), .rd_line(rd_line), .busy(busy));

  main_mem_rr #(.NUM_CH(1), .LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .DATA_W(DW),
                .RD_CYCLE(LS + 1), .WR_CYCLE(LS)) u_min (
    .clk(clk), .rst(rst), .req(m_req), .we(m_we), .addr(m_addr), .wr_line(m_wr_line),
    .wr_mask(m_wr_mask), .gnt(m_gnt), .rd_line(m_rd_line), .busy(m_busy));

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    bit          rd;
    logic [LW-1:0] line;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  bit   gnt_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [LW-1:0] mk_line(input int base);
    logic [LW-1:0] l;
    for (int i = 0; i < LS; i++) l[i*DW +: DW] = DW'(base + i);
    return l;
  endfunction

  // Expected line after a masked overwrite of a line holding old_base+i.
  function automatic logic [LW-1:0] mk_merge(input int new_base, input int old_base,
                                              input logic [LS-1:0] m);
    logic [LW-1:0] l;
    for (int i = 0; i < LS; i++) l[i*DW +: DW] = m[i] ? DW'(new_base + i) : DW'(old_base + i);
    return l;
  endfunction

  // Completion monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (gnt_prev) chk("busy_after_gnt", LW'(busy), LW'(0));
      gnt_prev = 1'b0;
      if (gnt != '0) begin
        gnt_prev = 1'b1;
        chk("gnt_onehot", LW'($countones(gnt)), LW'(1));
        if (sbq.size() == 0) begin
          chk("unexpected_gnt", LW'(gnt), LW'(0));
        end else begin
          e = sbq.pop_front();
          chk("gnt_channel", LW'(gnt), LW'(NCH'(1) << e.ch));
          if (e.rd)       chk("rd_line", rd_line, e.line);
          if (e.cyc >= 0) chk("gnt_latency", LW'(cyc), LW'(e.cyc));
        end
      end
    end
  end

  task automatic xact(input int ch, input bit w, input logic [AL-1:0] a,
                      input logic [LW-1:0] line, input logic [LS-1:0] m,
                      input logic [LW-1:0] exp_rd, input bit push, input bit lat_chk);
    int n = 0;
    @(negedge clk);
    req[ch] = 1'b1;
    we[ch]  = w;
    addr[ch*AL +: AL]    = a;
    wr_line[ch*LW +: LW] = line;
    wr_mask[ch*LS +: LS] = m;
    if (push) sbq.push_back('{ch, !w, exp_rd, lat_chk ? cyc + 1 + (w ? WRC : RDC) : -1});
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[ch] && n < 200);
    if (!gnt[ch]) chk("gnt_timeout", LW'(gnt[ch]), LW'(1));
    req[ch] = 1'b0;
  endtask

  task automatic m_xact(input bit w, input logic [AL-1:0] a, input logic [LW-1:0] line,
                        input logic [LS-1:0] m, input logic [LW-1:0] exp_rd, input int lat);
    int n = 0;
    @(negedge clk);
    m_req = 1'b1; m_we = w; m_addr = a; m_wr_line = line; m_wr_mask = m;
    do begin
      @(negedge clk);
      n++;
    end while (!m_gnt[0] && n < 100);
    chk("min_latency", LW'(n), LW'(lat + 1));
    if (!w) chk("min_rd_line", m_rd_line, exp_rd);
    m_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wr_line = '0; wr_mask = '0;
    m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wr_line = '0; m_wr_mask = '0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", LW'(gnt), LW'(0));
    chk("reset_busy", LW'(busy), LW'(0));
    chk("reset_rd_line", rd_line, '0);
    rst = 1'b0;

    // Full write then read back.
    xact(0, 1'b1, 8'h05, mk_line(32'hA0), 8'hFF, '0, 1'b1, 1'b1);
    xact(0, 1'b0, 8'h05, '0, '0, mk_line(32'hA0), 1'b1, 1'b1);

    // Partial mask, then an all-zero mask, then read on ch1.
    xact(0, 1'b1, 8'h05, mk_line(32'hB0), 8'h0F, '0, 1'b1, 1'b1);
    xact(0, 1'b1, 8'h05, mk_line(32'hF0), 8'h00, '0, 1'b1, 1'b1);
    xact(1, 1'b0, 8'h05, '0, '0, mk_merge(32'hB0, 32'hA0, 8'h0F), 1'b1, 1'b1);

    // Contention: both channels request continuously, grants alternate from ch0.
    sbq.push_back('{0, 1'b0, '0, -1});
    sbq.push_back('{1, 1'b0, '0, -1});
    sbq.push_back('{0, 1'b1, mk_line(32'hD0), -1});
    sbq.push_back('{1, 1'b1, mk_line(32'hC0), -1});
    fork
      begin
        xact(0, 1'b1, 8'h10, mk_line(32'hC0), 8'hFF, '0, 1'b0, 1'b0);
        xact(0, 1'b0, 8'h11, '0, '0, '0, 1'b0, 1'b0);
      end
      begin
        xact(1, 1'b1, 8'h11, mk_line(32'hD0), 8'hFF, '0, 1'b0, 1'b0);
        xact(1, 1'b0, 8'h10, '0, '0, '0, 1'b0, 1'b0);
      end
    join

    // Inputs changed after acceptance must not affect the access.
    fork
      xact(0, 1'b1, 8'h20, mk_line(32'hE0), 8'hFF, '0, 1'b1, 1'b1);
      begin
        repeat (2) @(negedge clk);
        addr[0 +: AL]    = 8'h21;
        wr_line[0 +: LW] = mk_line(32'h55);
        wr_mask[0 +: LS] = 8'h00;
        chk("busy_in_flight", LW'(busy), LW'(1));
        repeat (5) @(negedge clk);
        chk("busy_in_flight_late", LW'(busy), LW'(1));
      end
    join
    xact(1, 1'b0, 8'h20, '0, '0, mk_line(32'hE0), 1'b1, 1'b1);

    // Reset four cycles into a read aborts it.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0 +: AL] = 8'h05;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_gnt", LW'(gnt), LW'(0));
    chk("abort_busy", LW'(busy), LW'(0));
    chk("abort_rd_line", rd_line, '0);
    repeat (15) @(negedge clk);
    xact(0, 1'b0, 8'h05, '0, '0, mk_merge(32'hB0, 32'hA0, 8'h0F), 1'b1, 1'b1);

    // Minimum-latency build round trip.
    m_xact(1'b1, 8'h33, mk_line(32'h70), 8'hFF, '0, LS);
    m_xact(1'b1, 8'h33, mk_line(32'h90), 8'h81, '0, LS);
    m_xact(1'b0, 8'h33, '0, '0, mk_merge(32'h90, 32'h70, 8'h81), LS + 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", LW'(sbq.size()), LW'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
